cluster_mem_responder: RTL and testbench
========================================

# cluster_mem_responder

Memory-side responder for the single shared request port that the RV cluster arbiter presents to the memory system. It accepts instruction-fetch and data requests from whichever hart is currently selected, models a fixed access latency while driving `w_busy`, and returns 128-bit aligned lines. It also performs byte, half and word stores into an internal word array. It is the bring-up and simulation target for the cluster in place of the full DRAM controller.

## Interface
Parameters:
- `MEM_WORDS`, 16384: number of 32-bit words in the array; must be a power of 2 and at least 4.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0; must be 16-byte aligned.
- `LATENCY`, 4: wait cycles between accept and response; must be at least 1.

Ports:
- `CLK` in 1: the single clock.
- `RST_X` in 1: reset, asynchronous, active-low.
- `w_insn_req` in 1: fetch request strobe, sampled only in IDLE.
- `w_data_req` in 1: data request strobe, sampled only in IDLE.
- `w_cluster_iaddr` in 32: fetch byte address.
- `w_cluster_daddr` in 32: data byte address.
- `w_cluster_data_wdata` in 32: store data, LSB-aligned.
- `w_cluster_data_ctrl` in 3: bits [1:0] give size (00 byte, 01 half, 10/11 word); bit 2 is ignored by this block.
- `w_cluster_data_we` in 1: store when 1, load when 0; qualifies `w_data_req`.
- `w_busy` out 1: responder is occupied.
- `w_resp_valid` out 1: one-cycle response pulse.
- `w_resp_is_insn` out 1: the response being pulsed belongs to a fetch.
- `w_err` out 1: the response being pulsed carries an error; valid only with `w_resp_valid`.
- `w_insn_data` out 128: last fetch line.
- `w_data_data` out 128: last data line.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `w_data_req` high: latch daddr, wdata, ctrl and we; go to WAIT.
  - Only `w_insn_req` high: latch iaddr; go to WAIT.
  - Both high in the same cycle: the data request is serviced first. The fetch address is latched into a pending register, `r_pend` is set to 1, and the fetch is auto-serviced immediately after the data response with no new strobe needed.
- WAIT: a counter loads `LATENCY-1` on accept and decrements each cycle; at 0 the FSM goes to RESP.
- RESP (exactly one cycle):
  - `w_resp_valid`=1.
  - The result is registered into `w_insn_data` or `w_data_data`.
  - Next state is WAIT if `r_pend`=1 (clear `r_pend`, counter reloaded); otherwise IDLE.
- Range check: the offset is `addr - BASE_ADDR`, computed in 32-bit unsigned with wrap. The address is in range iff offset < `MEM_WORDS`*4.
- Line read:
  - Line word index = offset[31:4]·4.
  - Word k of the line occupies bits [32k+31:32k].
  - The returned line is the array content after any store in the same RESP (write-first).
- Store (we=1):
  - Byte: word[offset[1:0]·8 +: 8] = wdata[7:0].
  - Half: requires offset[0]=0; writes bits at offset[1]·16 +: 16 from wdata[15:0].
  - Word: requires offset[1:0]=0.
  - The array is written in the RESP cycle.
  - The data line is also returned, as post-write content.
- Errors:
  - Out of range, misaligned half, or misaligned word: `w_err`=1 in RESP.
  - No array write occurs.
  - The corresponding data output is set to 128'h0.
- Output hold: line outputs hold their value until the next response of the same kind.
- Reset: asynchronous assertion from any state forces IDLE, clears `r_pend` and the counter, and zeroes all outputs. Array contents are not reset.

## Timing
- Reset values: `w_busy`=0, `w_resp_valid`=0, `w_resp_is_insn`=0, `w_err`=0, `w_insn_data`=0, `w_data_data`=0.
- `w_busy` = (state != IDLE). It is registered-state decoded with no combinational path from the request inputs.
- Accept at edge t (IDLE, strobe high):
  - `w_busy` is high during cycles t+1 … t+LATENCY+1.
  - The RESP cycle is t+LATENCY+1, with `w_resp_valid`=1 and `w_busy`=1.
  - `w_busy`=0 at t+LATENCY+2 if nothing is pending.
- Outputs `w_resp_is_insn` and `w_err` are registered; they are valid only in the RESP cycle and 0 otherwise.
- Line data is visible from the cycle after RESP.
- Back-to-back: a new strobe is sampled at the earliest in the first IDLE cycle after RESP, giving minimum spacing of LATENCY+2 cycles.
- Simultaneous case: the pending fetch response occurs at t+2·LATENCY+2 (one RESP, then WAIT for LATENCY cycles, then a second RESP). `w_busy` stays high throughout.
- Strobes asserted while `w_busy`=1 are ignored and are not queued.

## Test plan
- Reset while in WAIT with `r_pend` set, then release: all outputs 0, FSM in IDLE, next fetch serviced normally, and array contents preserved.
- Word store then load, LATENCY=4:
  - Store 32'hDEADBEEF at BASE+8, then load BASE+8.
  - Load response at accept+5 with `w_data_data`[95:64]=32'hDEADBEEF and `w_err`=0.
  - `w_busy` high for exactly 5 cycles per request.
- Byte and half stores into a zeroed word at BASE+4:
  - Byte 8'hAA at BASE+5.
  - Half 16'h1234 at BASE+6.
  - Final word = 32'h1234AA00.
- Simultaneous `w_insn_req` (BASE+16) and `w_data_req` (load BASE):
  - Data RESP first at t+5 with `w_resp_is_insn`=0.
  - Fetch RESP at t+10 with `w_resp_is_insn`=1.
  - `w_busy` continuously high over t+1 … t+10.
- Error cases, each giving `w_err`=1 with line 128'h0 and no array change:
  - Word store at BASE+2.
  - Half store at BASE+1.
  - Load at BASE+`MEM_WORDS`*4.
  - Load at BASE-4.
- Strobe asserted during WAIT is ignored: exactly one `w_resp_valid` pulse is produced, and the ignored address's contents are never returned.

Source files
------------

// File: rtl/cluster_mem_responder.sv
// cluster_mem_responder
//   Memory-side responder for the cluster's shared request port. It accepts one
//   fetch or data request in IDLE, waits a fixed latency with w_busy high, then
//   pulses w_resp_valid for one cycle. It returns the 128-bit aligned line that
//   contains the address and performs byte/half/word stores into a word array.
//   When a fetch and a data request arrive together, the data request is served
//   first. The fetch is then replayed automatically from a pending register.
//
// Ports
//   CLK, RST_X               clock; asynchronous active-low reset
//   w_insn_req, w_data_req   request strobes, sampled only while idle
//   w_cluster_iaddr          fetch byte address
//   w_cluster_daddr          data byte address
//   w_cluster_data_wdata     store data, LSB-aligned
//   w_cluster_data_ctrl      [1:0] size: 00 byte, 01 half, 1x word; [2] unused
//   w_cluster_data_we        1 = store, 0 = load
//   w_busy                   responder occupied (state != IDLE)
//   w_resp_valid             one-cycle response pulse
//   w_resp_is_insn           pulsed response belongs to a fetch
//   w_err                    pulsed response carries an error
//   w_insn_data              last fetch line (held between fetch responses)
//   w_data_data              last data line (held between data responses)
module cluster_mem_responder #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 4
) (
  input  logic         CLK,
  input  logic         RST_X,
  input  logic         w_insn_req,
  input  logic         w_data_req,
  input  logic [31:0]  w_cluster_iaddr,
  input  logic [31:0]  w_cluster_daddr,
  input  logic [31:0]  w_cluster_data_wdata,
  input  logic [2:0]   w_cluster_data_ctrl,
  input  logic         w_cluster_data_we,
  output logic         w_busy,
  output logic         w_resp_valid,
  output logic         w_resp_is_insn,
  output logic         w_err,
  output logic [127:0] w_insn_data,
  output logic [127:0] w_data_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  // The span is computed in 33 bits so that a 4 GiB array cannot overflow it.
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_we;
  logic          r_is_insn;
  logic          r_pend;
  logic [31:0]   r_pend_addr;
  logic          r_resp_is_insn;
  logic          r_err;
  logic [127:0]  r_insn_data;
  logic [127:0]  r_data_data;

  logic [31:0]   mem [MEM_WORDS];

  // Control bit 2 carries nothing this block needs.
  logic unused_ctrl;
  assign unused_ctrl = w_cluster_data_ctrl[2];

  // ---------------------------------------------------------------------------
  // Address decode and store merge for the request currently held.
  // ---------------------------------------------------------------------------
  logic [31:0]   off;
  logic          in_range;
  logic          misalign;
  logic          acc_err;
  logic [AW-1:0] word_idx;
  logic [AW-1:0] line_base;
  logic [31:0]   new_word;
  logic          do_write;
  logic [127:0]  rd_line;

  assign off       = r_addr - BASE_ADDR;   // wraps, so addresses below BASE fail the range check
  assign in_range  = {1'b0, off} < SPAN;
  // Alignment matters only for stores; a line read ignores the low offset bits.
  assign misalign  = r_we && (((r_size == SZ_HALF) && off[0]) ||
                              (r_size[1] && (off[1:0] != 2'b00)));
  assign acc_err   = !in_range || misalign;
  assign word_idx  = off[AW+1:2];
  assign line_base = word_idx & ~AW'(3);
  assign do_write  = (state == S_RESP) && r_we && !acc_err;

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    new_word = mem[word_idx];
    case (r_size)
      SZ_BYTE: new_word[{off[1:0], 3'b000} +: 8]  = r_wdata[7:0];
      SZ_HALF: new_word[{off[1], 4'b0000} +: 16]  = r_wdata[15:0];
      default: new_word = r_wdata;
    endcase
  end

  // The returned line reflects the store made in the same RESP cycle.
  always_comb begin
    rd_line = '0;
    for (int k = 0; k < 4; k++) begin
      if (do_write && ((line_base | AW'(k)) == word_idx))
        rd_line[32*k +: 32] = new_word;
      else
        rd_line[32*k +: 32] = mem[line_base | AW'(k)];
    end
  end

  // NOTE: the array is deliberately left out of reset; only the control and
  // output registers are cleared, and contents survive a reset pulse.
  always_ff @(posedge CLK) begin
    if (do_write)
      mem[word_idx] <= new_word;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_X) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RST_X) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (w_data_req || w_insn_req) state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == '0)              state_nxt = S_RESP;
      S_RESP:  state_nxt = r_pend ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, latency counter, response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_size         <= '0;
      r_we           <= 1'b0;
      r_is_insn      <= 1'b0;
      r_pend         <= 1'b0;
      r_pend_addr    <= '0;
      r_resp_is_insn <= 1'b0;
      r_err          <= 1'b0;
      r_insn_data    <= '0;
      r_data_data    <= '0;
    end else begin
      // Response flags are nonzero only during the RESP cycle.
      r_resp_is_insn <= 1'b0;
      r_err          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (w_data_req) begin
            r_addr    <= w_cluster_daddr;
            r_wdata   <= w_cluster_data_wdata;
            r_size    <= w_cluster_data_ctrl[1:0];
            r_we      <= w_cluster_data_we;
            r_is_insn <= 1'b0;
            r_cnt     <= CNT_LOAD;
            if (w_insn_req) begin
              r_pend      <= 1'b1;
              r_pend_addr <= w_cluster_iaddr;
            end
          end else if (w_insn_req) begin
            r_addr    <= w_cluster_iaddr;
            r_we      <= 1'b0;
            r_is_insn <= 1'b1;
            r_cnt     <= CNT_LOAD;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_is_insn <= r_is_insn;
            r_err          <= acc_err;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (r_is_insn) r_insn_data <= acc_err ? '0 : rd_line;
          else           r_data_data <= acc_err ? '0 : rd_line;
          // Replay the fetch that arrived together with this data request.
          if (r_pend) begin
            r_pend    <= 1'b0;
            r_addr    <= r_pend_addr;
            r_we      <= 1'b0;
            r_is_insn <= 1'b1;
            r_cnt     <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_busy         = (state != S_IDLE);
  assign w_resp_valid   = (state == S_RESP);
  assign w_resp_is_insn = r_resp_is_insn;
  assign w_err          = r_err;
  assign w_insn_data    = r_insn_data;
  assign w_data_data    = r_data_data;

endmodule

// File: tb/tb_cluster_mem_responder.sv
// tb_cluster_mem_responder
//   Directed bench for cluster_mem_responder with default parameters
//   (MEM_WORDS=16384, BASE_ADDR=0x8000_0000, LATENCY=4). Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
module tb_cluster_mem_responder;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned MEM_WORDS = 16384;

  logic         CLK = 1'b0;
  logic         RST_X = 1'b0;
  logic         w_insn_req = 1'b0;
  logic         w_data_req = 1'b0;
  logic [31:0]  w_cluster_iaddr = '0;
  logic [31:0]  w_cluster_daddr = '0;
  logic [31:0]  w_cluster_data_wdata = '0;
  logic [2:0]   w_cluster_data_ctrl = '0;
  logic         w_cluster_data_we = 1'b0;
  logic         w_busy;
  logic         w_resp_valid;
  logic         w_resp_is_insn;
  logic         w_err;
  logic [127:0] w_insn_data;
  logic [127:0] w_data_data;

  cluster_mem_responder dut (
    .CLK                  (CLK),
    .RST_X                (RST_X),
    .w_insn_req           (w_insn_req),
    .w_data_req           (w_data_req),
    .w_cluster_iaddr      (w_cluster_iaddr),
    .w_cluster_daddr      (w_cluster_daddr),
    .w_cluster_data_wdata (w_cluster_data_wdata),
    .w_cluster_data_ctrl  (w_cluster_data_ctrl),
    .w_cluster_data_we    (w_cluster_data_we),
    .w_busy               (w_busy),
    .w_resp_valid         (w_resp_valid),
    .w_resp_is_insn       (w_resp_is_insn),
    .w_err                (w_err),
    .w_insn_data          (w_insn_data),
    .w_data_data          (w_data_data)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Results of the most recent wait_resp call.
  int   rs_lat;
  int   rs_busy;
  logic rs_insn;
  logic rs_err;
  logic rs_vld_after;
  logic rs_busy_after;

  // Expected line contents after the prime/store sequence.
  localparam logic [127:0] LINE0 = {32'hC0DE0003, 32'hDEADBEEF, 32'h1234AA00, 32'hC0DE0000};
  localparam logic [127:0] LINE1 = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present strobes for one rising edge; returns at the falling edge of the
  // first cycle after acceptance.
  task automatic issue(input logic ireq, input logic dreq, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [2:0] ctl, input logic we);
    @(negedge CLK);
    w_insn_req           = ireq;
    w_data_req           = dreq;
    w_cluster_iaddr      = ia;
    w_cluster_daddr      = da;
    w_cluster_data_wdata = wd;
    w_cluster_data_ctrl  = ctl;
    w_cluster_data_we    = we;
    @(negedge CLK);
    w_insn_req = 1'b0;
    w_data_req = 1'b0;
  endtask

  // Counts cycles (current cycle = 1) until w_resp_valid, bounded to 40.
  // Returns at the falling edge of the cycle after the response.
  task automatic wait_resp();
    rs_lat  = 1;
    rs_busy = 0;
    while (w_resp_valid !== 1'b1 && rs_lat < 40) begin
      if (w_busy === 1'b1) rs_busy++;
      @(negedge CLK);
      rs_lat++;
    end
    if (w_busy === 1'b1) rs_busy++;
    rs_insn = w_resp_is_insn;
    rs_err  = w_err;
    @(negedge CLK);
    rs_vld_after  = w_resp_valid;
    rs_busy_after = w_busy;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ctl);
    issue(1'b0, 1'b1, 32'h0, a, d, ctl, 1'b1);
    wait_resp();
  endtask

  task automatic do_load(input logic [31:0] a);
    issue(1'b0, 1'b1, 32'h0, a, 32'h0, 3'b010, 1'b0);
    wait_resp();
  endtask

  int pulses;

  initial begin
    // ---------------- reset state ----------------
    @(negedge CLK);
    @(negedge CLK);
    check("rst_busy",  w_busy, 0);
    check("rst_valid", w_resp_valid, 0);
    check("rst_flags", {w_resp_is_insn, w_err}, 0);
    check("rst_insn_line", w_insn_data, 0);
    check("rst_data_line", w_data_data, 0);
    RST_X = 1'b1;

    // ---------------- prime lines 0 and 1 ----------------
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      v = (i == 1) ? 32'h0 : {16'hC0DE, 16'(i)};
      do_store(BASE + 32'(4 * i), v, 3'b010);
      if (i == 0) begin
        check("store_lat",        rs_lat, 5);
        check("store_busy_cnt",   rs_busy, 5);
        check("store_err",        rs_err, 0);
        check("store_is_insn",    rs_insn, 0);
        check("store_valid_after", rs_vld_after, 0);
        check("store_busy_after", rs_busy_after, 0);
      end
    end

    // ---------------- word store then load ----------------
    do_store(BASE + 32'd8, 32'hDEADBEEF, 3'b010);
    check("wstore_line", w_data_data,
          {32'hC0DE0003, 32'hDEADBEEF, 32'h00000000, 32'hC0DE0000});
    do_load(BASE + 32'd8);
    check("wload_lat",      rs_lat, 5);
    check("wload_busy_cnt", rs_busy, 5);
    check("wload_err",      rs_err, 0);
    check("wload_word2",    w_data_data[95:64], 32'hDEADBEEF);

    // ---------------- byte and half stores ----------------
    do_store(BASE + 32'd5, 32'h123456AA, 3'b000);
    check("bstore_err",  rs_err, 0);
    check("bstore_word", w_data_data[63:32], 32'h0000AA00);
    do_store(BASE + 32'd6, 32'hFFFF1234, 3'b001);
    check("hstore_word", w_data_data[63:32], 32'h1234AA00);
    do_load(BASE + 32'd4);
    check("bh_load_word", w_data_data[63:32], 32'h1234AA00);

    // ---------------- simultaneous fetch + data load ----------------
    issue(1'b1, 1'b1, BASE + 32'd16, BASE, 32'h0, 3'b010, 1'b0);
    wait_resp();
    check("sim_data_lat",     rs_lat, 5);
    check("sim_data_is_insn", rs_insn, 0);
    check("sim_data_line",    w_data_data, LINE0);
    check("sim_busy_between", rs_busy_after, 1);
    begin
      int first_busy;
      first_busy = rs_busy;
      wait_resp();
      check("sim_fetch_lat",     rs_lat, 5);
      check("sim_busy_total",    first_busy + rs_busy, 10);
    end
    check("sim_fetch_is_insn", rs_insn, 1);
    check("sim_fetch_err",     rs_err, 0);
    check("sim_fetch_line",    w_insn_data, LINE1);
    check("sim_data_hold",     w_data_data, LINE0);
    check("sim_busy_after",    rs_busy_after, 0);

    // ---------------- error cases ----------------
    do_store(BASE + 32'd2, 32'hFFFFFFFF, 3'b010);
    check("err_wmis_err",  rs_err, 1);
    check("err_wmis_line", w_data_data, 0);
    do_store(BASE + 32'd1, 32'hFFFFFFFF, 3'b001);
    check("err_hmis_err",  rs_err, 1);
    check("err_hmis_line", w_data_data, 0);
    do_load(BASE);
    check("err_no_change", w_data_data, LINE0);
    do_load(BASE + 32'(MEM_WORDS * 4));
    check("err_oor_hi_err",  rs_err, 1);
    check("err_oor_hi_line", w_data_data, 0);
    do_load(BASE + 32'd16);
    check("reload_line1", w_data_data, LINE1);
    do_load(BASE - 32'd4);
    check("err_oor_lo_err",  rs_err, 1);
    check("err_oor_lo_line", w_data_data, 0);

    // ---------------- strobes during WAIT are ignored ----------------
    issue(1'b0, 1'b1, 32'h0, BASE + 32'd16, 32'h0, 3'b010, 1'b0);
    w_insn_req      = 1'b1;
    w_data_req      = 1'b1;
    w_cluster_iaddr = BASE;
    w_cluster_daddr = BASE;
    @(negedge CLK);
    w_insn_req = 1'b0;
    w_data_req = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (w_resp_valid === 1'b1) pulses++;
      @(negedge CLK);
    end
    check("ignore_pulses",    pulses, 1);
    check("ignore_data_line", w_data_data, LINE1);
    check("ignore_insn_line", w_insn_data, LINE1);

    // ---------------- reset in WAIT with pending fetch ----------------
    issue(1'b1, 1'b1, BASE + 32'd16, BASE, 32'h0, 3'b010, 1'b0);
    @(negedge CLK);
    #2 RST_X = 1'b0;
    #1;
    check("mid_rst_busy",  w_busy, 0);
    check("mid_rst_flags", {w_resp_valid, w_resp_is_insn, w_err}, 0);
    check("mid_rst_lines", w_insn_data | w_data_data, 0);
    @(negedge CLK);
    RST_X = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (w_resp_valid === 1'b1 || w_busy === 1'b1) pulses++;
      @(negedge CLK);
    end
    check("post_rst_idle", pulses, 0);
    issue(1'b1, 1'b0, BASE, 32'h0, 32'h0, 3'b000, 1'b0);
    wait_resp();
    check("post_rst_fetch_lat",  rs_lat, 5);
    check("post_rst_fetch_insn", rs_insn, 1);
    check("post_rst_mem_kept",   w_insn_data, LINE0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
